// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: registered execute stage with valid/ready handshake and an iterative
// shift-add unsigned multiplier. Define EX_MULH_EN to add MULH (FS=0x11, high product half).
module ex_stage_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int SH_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a_bus,
  input  logic [DATA_W-1:0] b_bus,
  input  logic [ADDR_W-1:0] pc_n2,
  input  logic [4:0]        fs,
  input  logic [SH_W-1:0]   sh,
  input  logic              mw,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] f,
  output logic              v,
  output logic              c,
  output logic              n,
  output logic              z,
  output logic              nxorv,
  output logic              lco,
  output logic              rco,
  output logic [ADDR_W-1:0] bra,
  output logic [ADDR_W-1:0] raa,
  output logic              mw_q,
  output logic              busy
);

  localparam int MSB   = DATA_W - 1;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  localparam logic [4:0] FS_A   = 5'h00;
  localparam logic [4:0] FS_INC = 5'h01;
  localparam logic [4:0] FS_ADD = 5'h02;
  localparam logic [4:0] FS_SUB = 5'h05;
  localparam logic [4:0] FS_AND = 5'h08;
  localparam logic [4:0] FS_OR  = 5'h09;
  localparam logic [4:0] FS_XOR = 5'h0A;
  localparam logic [4:0] FS_NOT = 5'h0B;
  localparam logic [4:0] FS_B   = 5'h0C;
  localparam logic [4:0] FS_SRL = 5'h0D;
  localparam logic [4:0] FS_SLL = 5'h0E;
  localparam logic [4:0] FS_MUL = 5'h10;
`ifdef EX_MULH_EN
  localparam logic [4:0] FS_MULH = 5'h11;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_r, state_nx;

  logic [CNT_W-1:0]    cnt_r;
  logic [DATA_W-1:0]   mcand_r;
  logic [2*DATA_W-1:0] acc_r;
  logic                mulh_r;
  logic [ADDR_W-1:0]   pend_bra_r;
  logic [ADDR_W-1:0]   pend_raa_r;
  logic                pend_mw_r;

  logic out_free_s, accept_s, is_mul_s, is_mulh_s, load_alu_s, load_mul_s;
  logic [ADDR_W-1:0] bra_s;

  logic [DATA_W:0]   sum_s;
  logic [DATA_W:0]   sll_w_s;
  logic [DATA_W:0]   srl_w_s;
  logic [DATA_W-1:0] alu_f_s;
  logic              alu_c_s, alu_v_s, alu_lco_s, alu_rco_s;

  logic [DATA_W:0]     addend_s;
  logic [DATA_W:0]     mstep_s;
  logic [2*DATA_W-1:0] acc_nx_s;
  logic [DATA_W-1:0]   mul_f_s;
  logic                mul_c_s;

  // Handshake and operation-class decode
  always_comb begin
    out_free_s = !out_valid || out_ready;
    in_ready   = reset && (state_r == IDLE) && out_free_s;
    accept_s   = in_valid && in_ready;
    is_mulh_s  = 1'b0;
`ifdef EX_MULH_EN
    is_mulh_s  = (fs == FS_MULH);
`endif
    is_mul_s   = (fs == FS_MUL) || is_mulh_s;
    load_alu_s = accept_s && !is_mul_s;
    load_mul_s = (state_r == DONE) && out_free_s;
    bra_s      = b_bus[ADDR_W-1:0] + pc_n2;
  end

  // Single-cycle ALU/shifter; shifts use a guard bit to expose the last bit shifted out
  always_comb begin
    alu_f_s   = {DATA_W{1'b0}};
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    alu_lco_s = 1'b0;
    alu_rco_s = 1'b0;
    sum_s     = {(DATA_W+1){1'b0}};
    sll_w_s   = {1'b0, a_bus} << sh;
    srl_w_s   = {a_bus, 1'b0} >> sh;
    case (fs)
      FS_A:   alu_f_s = a_bus;
      FS_INC: begin
        sum_s   = {1'b0, a_bus} + {{DATA_W{1'b0}}, 1'b1};
        alu_f_s = sum_s[DATA_W-1:0];
        alu_c_s = sum_s[DATA_W];
        alu_v_s = !a_bus[MSB] && sum_s[MSB];
      end
      FS_ADD: begin
        sum_s   = {1'b0, a_bus} + {1'b0, b_bus};
        alu_f_s = sum_s[DATA_W-1:0];
        alu_c_s = sum_s[DATA_W];
        alu_v_s = (a_bus[MSB] == b_bus[MSB]) && (sum_s[MSB] != a_bus[MSB]);
      end
      FS_SUB: begin
        sum_s   = {1'b0, a_bus} + {1'b0, ~b_bus} + {{DATA_W{1'b0}}, 1'b1};
        alu_f_s = sum_s[DATA_W-1:0];
        alu_c_s = sum_s[DATA_W];
        alu_v_s = (a_bus[MSB] != b_bus[MSB]) && (sum_s[MSB] != a_bus[MSB]);
      end
      FS_AND: alu_f_s = a_bus & b_bus;
      FS_OR:  alu_f_s = a_bus | b_bus;
      FS_XOR: alu_f_s = a_bus ^ b_bus;
      FS_NOT: alu_f_s = ~a_bus;
      FS_B:   alu_f_s = b_bus;
      FS_SRL: begin
        alu_f_s   = srl_w_s[DATA_W:1];
        alu_rco_s = srl_w_s[0];
      end
      FS_SLL: begin
        alu_f_s   = sll_w_s[DATA_W-1:0];
        alu_lco_s = sll_w_s[DATA_W];
      end
      default: alu_f_s = {DATA_W{1'b0}};
    endcase
  end

  // One shift-add step: conditionally add multiplicand to the high half, shift right
  always_comb begin
    addend_s = acc_r[0] ? {1'b0, mcand_r} : {(DATA_W+1){1'b0}};
    mstep_s  = {1'b0, acc_r[2*DATA_W-1:DATA_W]} + addend_s;
    acc_nx_s = {mstep_s, acc_r[DATA_W-1:1]};
    mul_f_s  = mulh_r ? acc_r[2*DATA_W-1:DATA_W] : acc_r[DATA_W-1:0];
    mul_c_s  = mulh_r && (acc_r[2*DATA_W-1:DATA_W] != {DATA_W{1'b0}});
  end

  // Multiply sequencer next-state
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && is_mul_s) state_nx = MULT;
        else                      state_nx = IDLE;
      end
      MULT: begin
        if (cnt_r == CNT_ONE) state_nx = DONE;
        else                  state_nx = MULT;
      end
      DONE: begin
        if (out_free_s) state_nx = IDLE;
        else            state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_nx;
  end

  // Multiplier datapath plus side-band fields captured at MUL accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r      <= {CNT_W{1'b0}};
      mcand_r    <= {DATA_W{1'b0}};
      acc_r      <= {(2*DATA_W){1'b0}};
      mulh_r     <= 1'b0;
      pend_bra_r <= {ADDR_W{1'b0}};
      pend_raa_r <= {ADDR_W{1'b0}};
      pend_mw_r  <= 1'b0;
    end else if (accept_s && is_mul_s) begin
      cnt_r      <= CNT_FULL;
      mcand_r    <= a_bus;
      acc_r      <= {{DATA_W{1'b0}}, b_bus};
      mulh_r     <= is_mulh_s;
      pend_bra_r <= bra_s;
      pend_raa_r <= a_bus[ADDR_W-1:0];
      pend_mw_r  <= mw;
    end else if (state_r == MULT) begin
      cnt_r <= cnt_r - CNT_ONE;
      acc_r <= acc_nx_s;
    end
  end

  // Output register: every field loads together and holds while stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      f         <= {DATA_W{1'b0}};
      v         <= 1'b0;
      c         <= 1'b0;
      n         <= 1'b0;
      z         <= 1'b0;
      nxorv     <= 1'b0;
      lco       <= 1'b0;
      rco       <= 1'b0;
      bra       <= {ADDR_W{1'b0}};
      raa       <= {ADDR_W{1'b0}};
      mw_q      <= 1'b0;
    end else if (load_alu_s) begin
      out_valid <= 1'b1;
      f         <= alu_f_s;
      v         <= alu_v_s;
      c         <= alu_c_s;
      n         <= alu_f_s[MSB];
      z         <= (alu_f_s == {DATA_W{1'b0}});
      nxorv     <= alu_f_s[MSB] ^ alu_v_s;
      lco       <= alu_lco_s;
      rco       <= alu_rco_s;
      bra       <= bra_s;
      raa       <= a_bus[ADDR_W-1:0];
      mw_q      <= mw;
    end else if (load_mul_s) begin
      out_valid <= 1'b1;
      f         <= mul_f_s;
      v         <= 1'b0;
      c         <= mul_c_s;
      n         <= mul_f_s[MSB];
      z         <= (mul_f_s == {DATA_W{1'b0}});
      nxorv     <= mul_f_s[MSB];
      lco       <= 1'b0;
      rco       <= 1'b0;
      bra       <= pend_bra_r;
      raa       <= pend_raa_r;
      mw_q      <= pend_mw_r;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign busy = (state_r == MULT);

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Self-checking bench for ex_stage_pipe (DATA_W=32, ADDR_W=16): directed cases plus
// randomized traffic scored against an arithmetic reference model.
module tb_ex_stage_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_bus, b_bus;
  logic [15:0] pc_n2;
  logic [4:0]  fs;
  logic [4:0]  sh;
  logic        mw;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] f;
  logic        v, c, n, z, nxorv, lco, rco;
  logic [15:0] bra, raa;
  logic        mw_q;
  logic        busy;

  int checks = 0;
  int failures = 0;

  typedef logic [71:0] pk_t;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  ex_stage_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a_bus(a_bus), .b_bus(b_bus), .pc_n2(pc_n2), .fs(fs), .sh(sh), .mw(mw),
    .out_valid(out_valid), .out_ready(out_ready), .f(f), .v(v), .c(c), .n(n),
    .z(z), .nxorv(nxorv), .lco(lco), .rco(rco), .bra(bra), .raa(raa),
    .mw_q(mw_q), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic pk_t obs();
    return {f, v, c, n, z, nxorv, lco, rco, bra, raa, mw_q};
  endfunction

  // Reference: expected output record computed from the operation's arithmetic meaning
  function automatic pk_t model(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                                input logic [4:0] s, input logic [15:0] pc, input logic w);
    logic [31:0] r;
    logic [15:0] br;
    logic cf, vf, lf, rf, zf, nf;
    longint sa, sb, sr;
    longint unsigned ua, ub, prod;
    r = 32'd0; cf = 1'b0; vf = 1'b0; lf = 1'b0; rf = 1'b0;
    sa = $signed(a); sb = $signed(b); ua = a; ub = b;
    case (op)
      5'h00: r = a;
      5'h01: begin r = a + 32'd1; cf = (ua + 64'd1) > 64'hFFFF_FFFF; sr = sa + 64'sd1; vf = (sr > MAXS) || (sr < MINS); end
      5'h02: begin r = a + b; cf = (ua + ub) > 64'hFFFF_FFFF; sr = sa + sb; vf = (sr > MAXS) || (sr < MINS); end
      5'h05: begin r = a - b; cf = (a >= b); sr = sa - sb; vf = (sr > MAXS) || (sr < MINS); end
      5'h08: r = a & b;
      5'h09: r = a | b;
      5'h0A: r = a ^ b;
      5'h0B: r = ~a;
      5'h0C: r = b;
      5'h0D: begin r = a >> s; rf = (s != 5'd0) ? a[s - 5'd1] : 1'b0; end
      5'h0E: begin r = a << s; lf = (s != 5'd0) ? a[32 - s] : 1'b0; end
      5'h10: begin prod = ua * ub; r = prod[31:0]; end
`ifdef EX_MULH_EN
      5'h11: begin prod = ua * ub; r = prod[63:32]; cf = (r != 32'd0); end
`endif
      default: r = 32'd0;
    endcase
    zf = (r == 32'd0);
    nf = r[31];
    br = b[15:0] + pc;
    return {r, vf, cf, nf, zf, nf ^ vf, lf, rf, br, a[15:0], w};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                       input logic [4:0] s, input logic [15:0] pc, input logic w);
    a_bus = a; b_bus = b; fs = op; sh = s; pc_n2 = pc; mw = w;
    in_valid = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({obs(), out_valid, busy, in_ready} !== 75'd0) begin
      failures++; $display("FAIL reset_init got=%h exp=0", {obs(), out_valid, busy, in_ready});
    end
    step(); reset = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_release in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
    out_ready = 1'b0;
    drive(32'h1234_5678, 32'h1111_1111, 5'h02, 5'd0, 16'h0042, 1'b1);
    step(); in_valid = 1'b0;
    #2 reset = 1'b0; #1;
    checks++;
    if ({obs(), out_valid, busy, in_ready} !== 75'd0) begin
      failures++; $display("FAIL reset_mid got=%h exp=0", {obs(), out_valid, busy, in_ready});
    end
    step(); reset = 1'b1; out_ready = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_mid_release in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_add();
    pk_t e;
    drive(32'hFFFF_FFFF, 32'h0000_0001, 5'h02, 5'd0, 16'h0100, 1'b0);
    e = model(32'hFFFF_FFFF, 32'h0000_0001, 5'h02, 5'd0, 16'h0100, 1'b0);
    step(); in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || obs() !== e || {f, z, c, v} !== {32'd0, 3'b110}) begin
      failures++; $display("FAIL add_wrap valid=%b got=%h exp=%h", out_valid, obs(), e);
    end
    drive(32'h7FFF_FFFF, 32'h0000_0001, 5'h02, 5'd0, 16'h0100, 1'b1);
    e = model(32'h7FFF_FFFF, 32'h0000_0001, 5'h02, 5'd0, 16'h0100, 1'b1);
    step(); in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || obs() !== e || {f, n, v, nxorv} !== {32'h8000_0000, 3'b110}) begin
      failures++; $display("FAIL add_ovf valid=%b got=%h exp=%h", out_valid, obs(), e);
    end
  endtask

  task automatic test_sub_branch();
    pk_t e;
    drive(32'd5, 32'd7, 5'h05, 5'd0, 16'h0010, 1'b1);
    e = model(32'd5, 32'd7, 5'h05, 5'd0, 16'h0010, 1'b1);
    step(); in_valid = 1'b0;
    checks++;
    if (obs() !== e || f !== 32'hFFFF_FFFE || c !== 1'b0 || n !== 1'b1 ||
        bra !== 16'h0017 || raa !== 16'h0005 || mw_q !== 1'b1) begin
      failures++; $display("FAIL sub_branch got=%h exp=%h", obs(), e);
    end
  endtask

  task automatic test_shifts();
    logic [4:0] ops [4] = '{5'h0E, 5'h0D, 5'h0E, 5'h0D};
    logic [4:0] shs [4] = '{5'd1, 5'd1, 5'd0, 5'd0};
    logic [31:0] fx [4] = '{32'h0000_0002, 32'h4000_0000, 32'h8000_0001, 32'h8000_0001};
    pk_t e;
    for (int i = 0; i < 4; i++) begin
      drive(32'h8000_0001, 32'h0, ops[i], shs[i], 16'h0, 1'b0);
      e = model(32'h8000_0001, 32'h0, ops[i], shs[i], 16'h0, 1'b0);
      step(); in_valid = 1'b0;
      checks++;
      if (obs() !== e || f !== fx[i] || lco !== (i == 0) || rco !== (i == 1)) begin
        failures++; $display("FAIL shift_%0d got=%h exp=%h", i, obs(), e);
      end
    end
  endtask

  task automatic test_mul_backpressure();
    pk_t e, held;
    int bad;
    out_ready = 1'b1;
    drive(32'h0001_0003, 32'h0002_0005, 5'h10, 5'd3, 16'h0100, 1'b1);
    e = model(32'h0001_0003, 32'h0002_0005, 5'h10, 5'd3, 16'h0100, 1'b1);
    step(); in_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL mul_busy_window bad_cycles=%0d exp=0", bad);
    end
    out_ready = 1'b0; #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL mul_done_state busy=%b valid=%b in_ready=%b exp 0/0/0", busy, out_valid, in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || obs() !== e || f !== 32'h000B_000F) begin
      failures++; $display("FAIL mul_result valid=%b got=%h exp=%h", out_valid, obs(), e);
    end
    held = obs(); bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (obs() !== held || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL mul_stall_hold bad_cycles=%0d exp=0", bad);
    end
    out_ready = 1'b1; #1;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL mul_drain valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
    end
`ifdef EX_MULH_EN
    drive(32'h0001_0003, 32'h0002_0005, 5'h11, 5'd0, 16'h0200, 1'b0);
    e = model(32'h0001_0003, 32'h0002_0005, 5'h11, 5'd0, 16'h0200, 1'b0);
    step(); in_valid = 1'b0;
    for (int i = 0; i < 33; i++) step();
    checks++;
    if (out_valid !== 1'b1 || obs() !== e || f !== 32'h0000_0002 || c !== 1'b1) begin
      failures++; $display("FAIL mulh_result valid=%b got=%h exp=%h", out_valid, obs(), e);
    end
    step();
`endif
  endtask

  task automatic test_back_to_back();
    pk_t e;
    logic [31:0] a, b;
    int bad;
    out_ready = 1'b1; bad = 0;
    for (int k = 0; k < 4; k++) begin
      a = $urandom; b = $urandom;
      drive(a, b, 5'h02, 5'd0, 16'(k), 1'b0);
      e = model(a, b, 5'h02, 5'd0, 16'(k), 1'b0);
      if (in_ready !== 1'b1) bad++;
      step();
      checks++;
      if (out_valid !== 1'b1 || obs() !== e) begin
        failures++; $display("FAIL b2b_%0d valid=%b got=%h exp=%h", k, out_valid, obs(), e);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (bad != 0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_ready stalls=%0d valid=%b exp 0/0", bad, out_valid);
    end
  endtask

  task automatic test_random();
    pk_t q[$];
    pk_t e;
    logic [4:0] optab [15] = '{5'h00, 5'h01, 5'h02, 5'h05, 5'h08, 5'h09, 5'h0A, 5'h0B,
                               5'h0C, 5'h0D, 5'h0E, 5'h10, 5'h11, 5'h1F, 5'h03};
    logic [4:0] op;
    int spurious = 0;
    for (int i = 0; i < 600; i++) begin
      op = optab[$urandom_range(0, 14)];
      if ((op == 5'h10 || op == 5'h11) && $urandom_range(0, 3) != 0) op = 5'h05;
      a_bus = $urandom; b_bus = ($urandom_range(0, 7) == 0) ? a_bus : $urandom;
      if ($urandom_range(0, 7) == 0) a_bus = 32'h7FFF_FFFF;
      fs = op; sh = 5'($urandom_range(0, 31)); pc_n2 = 16'($urandom); mw = 1'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) spurious++;
        else begin
          e = q.pop_front();
          checks++;
          if (obs() !== e) begin
            failures++; $display("FAIL rand_%0d got=%h exp=%h", i, obs(), e);
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model(a_bus, b_bus, fs, sh, pc_n2, mw));
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 100 && q.size() > 0; i++) begin
      #1;
      if (out_valid) begin
        e = q.pop_front();
        checks++;
        if (obs() !== e) begin
          failures++; $display("FAIL rand_drain_%0d got=%h exp=%h", i, obs(), e);
        end
      end
      step();
    end
    checks++;
    if (q.size() != 0 || spurious != 0) begin
      failures++; $display("FAIL rand_accounting pending=%0d spurious=%0d exp 0/0", q.size(), spurious);
    end
  endtask

  task automatic test_abort();
    int seen;
    out_ready = 1'b1;
    drive(32'hDEAD_BEEF, 32'h0000_0003, 5'h10, 5'd0, 16'h0, 1'b1);
    step(); in_valid = 1'b0;
    repeat (10) step();
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL abort_pre busy=%b exp=1", busy);
    end
    #2 reset = 1'b0; #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || obs() !== 72'd0) begin
      failures++; $display("FAIL abort_now busy=%b valid=%b got=%h exp 0/0/0", busy, out_valid, obs());
    end
    step(); reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL abort_no_result bad_cycles=%0d in_ready=%b exp 0/1", seen, in_ready);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a_bus = 32'd0; b_bus = 32'd0; pc_n2 = 16'd0; fs = 5'd0; sh = 5'd0; mw = 1'b0;
    test_reset();
    test_add();
    test_sub_branch();
    test_shifts();
    test_mul_backpressure();
    test_back_to_back();
    test_random();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_stage_pipe.md
Name: ex_stage_pipe

Overview:
- Parametrised, registered successor to the single-cycle execute stage.
- Accepts one operation per cycle over a valid/ready handshake and computes ALU/shift results, status flags, branch target and register-jump address.
- Adds an iterative multi-cycle unsigned multiply.
- Sits between the operand-fetch and memory stages; the memory stage consumes all outputs from the output register.

Parameters:
- DATA_W, 32: operand/result width (≥8).
- ADDR_W, 16: PC/branch/jump address width (≤ DATA_W).
- SH_W, 5: shift-amount width; SH_W = clog2(DATA_W).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  stage can accept
- a_bus  in  DATA_W  operand A
- b_bus  in  DATA_W  operand B
- pc_n2  in  ADDR_W  PC of instruction + 2
- fs  in  5  function select
- sh  in  SH_W  shift amount
- mw  in  1  memory write request, passed through
- out_valid  out  1  result register holds valid data
- out_ready  in  1  downstream accepts
- f  out  DATA_W  result
- v, c, n, z, nxorv  out  1 each  flags; nxorv = n^v
- lco, rco  out  1 each  last bit shifted out, left/right
- bra  out  ADDR_W  b_bus[ADDR_W-1:0] + pc_n2, modulo 2^ADDR_W
- raa  out  ADDR_W  a_bus[ADDR_W-1:0]
- mw_q  out  1  registered mw; valid only while out_valid
- busy  out  1  multiply in progress

Behaviour:
- Reset (async, reset=0): all outputs 0, state IDLE, multiply counter 0. A reset mid-multiply aborts it; no result is produced.
- Accept: in_valid && in_ready at a rising edge.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Output register: f, flags, bra, raa, mw_q all load together and hold stable while out_valid && !out_ready. out_valid clears on out_ready unless a new result loads on the same edge.
- Single-cycle ops: result registered on the accepting edge, so out_valid=1 after that edge. Full throughput; back-to-back accepts occur while out_ready=1.
- FS codes:
  - 0x00 A
  - 0x01 A+1
  - 0x02 A+B
  - 0x05 A-B
  - 0x08 A&B
  - 0x09 A|B
  - 0x0A A^B
  - 0x0B ~A
  - 0x0C B
  - 0x0D A>>sh (logical)
  - 0x0E A<<sh
  - 0x10 MUL, low DATA_W bits of unsigned A*B
  - any other code: f=0, all flags 0 except z=1
- Flags:
  - z = (f==0); n = f[DATA_W-1].
  - Add/inc/sub: c = carry-out of A+B, A+1, or A+~B+1 respectively (sub c=1 means no borrow). v = two's-complement overflow.
  - Logic, pass, shift and MUL: c=v=0.
  - lco = A[DATA_W-sh] for SLL with sh≠0, else 0. rco = A[sh-1] for SRL with sh≠0, else 0.
  - sh=0 shifts return A unchanged.
- FSM:
  - IDLE: on accept of MUL go to MULT, load multiplicand/multiplier/2·DATA_W accumulator, counter = DATA_W.
  - MULT: busy=1, in_ready=0. One shift-add step per cycle; counter decrements.
  - When the counter reaches 0, go to DONE.
  - DONE: if !out_valid || out_ready, load the result, set out_valid, go to IDLE; otherwise wait.
- MUL latency: result visible after the (DATA_W+1)-th edge after acceptance when unstalled.
- Results on the output already pending during MULT drain normally via out_ready.
- bra, raa and mw_q are captured at accept time for every op, including MUL.

Optional Feature:
- Macro EX_MULH_EN.
- Defined: FS=0x11 is MULH, returning the high DATA_W bits of the unsigned product. Same latency and flags as MUL, except c = (high half ≠ 0).
- Undefined: 0x11 is an undefined code (f=0, z=1), single-cycle.

Test Plan:
- Reset: assert reset=0 mid-stream → all outputs 0, in_ready=1 after release, out_valid=0.
- ADD: A=0xFFFFFFFF, B=0x00000001, FS=0x02 → f=0, z=1, c=1, v=0 one cycle later. Then A=0x7FFFFFFF, B=1 → f=0x80000000, n=1, v=1, nxorv=0.
- SUB/branch: A=5, B=7, FS=0x05, pc_n2=0x0010 → f=0xFFFFFFFE, c=0, n=1. bra=0x0017, raa=0x0005.
- Shifts: A=0x80000001, FS=0x0E, sh=1 → f=0x00000002, lco=1. FS=0x0D, sh=1 → f=0x40000000, rco=1. sh=0 → f=A, lco=rco=0.
- MUL with back-pressure: A=0x00010003, B=0x00020005, FS=0x10 → busy/in_ready=0 for 32 cycles; f=0x000B000F after the 33rd edge. Hold out_ready=0 for 5 cycles → f stable, in_ready=0. With EX_MULH_EN, FS=0x11 gives f=0x00000002, c=1.
- Throughput/abort: 4 back-to-back ADDs with out_ready=1 → 4 consecutive out_valid cycles. Reset asserted at multiply cycle 10 → no result emitted and busy=0 immediately.
